mmio_seg_responder: RTL
=======================

// Module: mmio_seg_responder
// PURPOSE
//   Memory-mapped I/O responder on the CPU54 data-memory bus. Decodes CPU load/store
//   requests in the 0x1001_00xx window, holds the seven-segment, LED and control registers,
//   and returns switch state on reads. Drives a time-multiplexed 8-digit hex display.
//   It is the slave end of the same bus that the CPU data path initiates.
// PARAMETERS
//   BASE_ADDR        32'h1001_0000  base of the 32-byte register window
//   SCAN_DIV         16'd50000      clk cycles per displayed digit (>=2)
//   DEBOUNCE_CYCLES  20'd500000     stable cycles before a switch change is accepted (macro only)
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   reset      in   1   synchronous, active-low reset
//   addr       in   32  byte address from CPU (Z register / ALU result)
//   wdata      in   32  store data
//   we         in   1   store strobe, one cycle per access
//   re         in   1   load strobe, one cycle per access
//   rdata      out  32  load data, valid while ack=1
//   ack        out  1   one-cycle completion pulse for any in-window access
//   sw         in   16  raw board switches (asynchronous)
//   led        out  16  LED register
//   an         out  8   digit enables, active-low, one-hot
//   seg        out  8   segments {dp,g..a}, active-low
// BEHAVIOUR
//   Register map (offset from BASE_ADDR; addr[1:0] ignored; word access only):
//     0x00 SEG   RW 32  eight hex digits, digit0 = [3:0] on an[0]
//     0x04 LED   RW 16  led = LED[15:0]; upper read bits 0
//     0x08 CTRL  RW 9   [0] display enable, [8:1] per-digit blank mask (1 = blank)
//     0x10 SW    RO 16  {16'b0, sw_filtered}; writes ignored but acked
//     other in-window offsets: write ignored, read returns 0, still acked
//   Hit = addr[31:5] == BASE_ADDR[31:5] and (we|re). Out-of-window: no ack, no state change.
//   Latency: request in cycle N -> registers updated and ack=1, rdata valid in cycle N+1.
//   Back-to-back requests every cycle accepted; each produces its own ack.
//   we and re both high: handled as a write; ack=1, rdata=0.
//   rdata is 0 whenever ack=0.
//   Read of a register written in the previous cycle returns the new value.
//   Switch path: 2-flop synchronizer into sw_filtered.
//   Scan: scan_cnt counts 0..SCAN_DIV-1, wraps to 0; on wrap, digit idx 0..7 increments and
//     wraps 7->0. an = ~(1<<idx) unless CTRL[0]=0 or CTRL[idx+1]=1, then an = 8'hFF.
//   seg = active-low hex decode of SEG nibble idx (0-F standard glyphs), dp always off (bit7=1).
//   Reset (reset=0 at clk edge): SEG=0, LED=0, CTRL=9'h001, scan_cnt=0, idx=0, ack=0,
//     rdata=0, sync flops=0, led=0, an=8'hFE, seg=8'hC0 (glyph '0').
//   Reset while a request is pending: request dropped, no ack is produced.
// CONFIGURATION
//   MMIO_SEG_DEBOUNCE_EN defined: after the synchronizer, each switch bit has a counter; the
//     filtered bit updates only after the synchronized value differs from it for
//     DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that bit's count.
//   Not defined: sw_filtered = synchronizer output (2-cycle latency), no counters built.
// TESTING
//   Reset: hold reset=0 3 cycles -> ack=0, rdata=0, led=0, an=8'hFE, seg=8'hC0.
//   Write 0x1001_0000 <= 32'h1234_ABCD, then read -> ack next cycle, rdata=32'h1234_ABCD;
//     with SCAN_DIV=4, an steps FE,FD,...,7F every 4 cycles, seg shows D,C,B,A,4,3,2,1.
//   Write LED 32'hFFFF_5A5A -> led=16'h5A5A; read back 32'h0000_5A5A. Write CTRL 9'h0FF ->
//     digits 0-6 blanked (an=FF), digit7 (idx 7) lit; write CTRL 0 -> an=FF for all idx.
//   sw=16'hBEEF, read 0x1001_0010 after 3 cycles -> rdata=32'h0000_BEEF; write to it is acked,
//     register unchanged; read 0x1001_0018 -> ack=1, rdata=0; addr 0x1001_0020 -> no ack.
//   Back-to-back: write SEG, read SEG, we&re on LED in consecutive cycles -> three acks,
//     rdata = 0, new SEG value, 0; LED updated.
//   Debounce (macro, DEBOUNCE_CYCLES=8): sw[0] toggles every 3 cycles -> SW read stays 0;
//     held high 12 cycles -> SW[0]=1. Reset mid-request -> no ack, SEG unchanged at 0.

Source files
------------

// File: rtl/mmio_seg_responder.sv
// mmio_seg_responder: memory-mapped slave on the CPU54 data bus.
// Holds the seven-segment, LED and control registers in a 32-byte window at
// BASE_ADDR, returns the synchronized switch state on reads, and scans an
// 8-digit multiplexed hex display.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   addr/wdata/we/re  single-cycle load/store request from the CPU
//   rdata/ack         registered response, one cycle after the request
//   sw                raw asynchronous board switches
//   led               LED register
//   an/seg            active-low digit enables and segments {dp,g..a}
//
// Optional build macro: MMIO_SEG_DEBOUNCE_EN adds a per-switch debounce
// counter (DEBOUNCE_CYCLES stable cycles) behind the synchronizer.
module mmio_seg_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter logic [15:0] SCAN_DIV  = 16'd50000
`ifdef MMIO_SEG_DEBOUNCE_EN
  ,parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        ack,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned SW_W  = 16;
  localparam int unsigned IDX_W = 3;

  localparam logic [2:0] OFF_SEG  = 3'd0;
  localparam logic [2:0] OFF_LED  = 3'd1;
  localparam logic [2:0] OFF_CTRL = 3'd2;
  localparam logic [2:0] OFF_SW   = 3'd4;

  logic [31:0]      seg_reg, seg_reg_nx;
  logic [15:0]      led_nx;
  logic [8:0]       ctrl_reg, ctrl_nx;
  logic [15:0]      scan_cnt, scan_cnt_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [31:0]      rdata_nx;
  logic [7:0]       an_nx, seg_nx;
  logic [3:0]       nib_c;
  logic             hit_c;
  logic [2:0]       off_c;
  logic [SW_W-1:0]  sw_meta, sw_sync, sw_filtered;
  logic [1:0]       addr_unused_c;

  assign addr_unused_c = addr[1:0];

  // Active-low hex glyphs, dp off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 8'hC0;
      4'h1: hex_glyph = 8'hF9;
      4'h2: hex_glyph = 8'hA4;
      4'h3: hex_glyph = 8'hB0;
      4'h4: hex_glyph = 8'h99;
      4'h5: hex_glyph = 8'h92;
      4'h6: hex_glyph = 8'h82;
      4'h7: hex_glyph = 8'hF8;
      4'h8: hex_glyph = 8'h80;
      4'h9: hex_glyph = 8'h90;
      4'hA: hex_glyph = 8'h88;
      4'hB: hex_glyph = 8'h83;
      4'hC: hex_glyph = 8'hC6;
      4'hD: hex_glyph = 8'hA1;
      4'hE: hex_glyph = 8'h86;
      default: hex_glyph = 8'h8E;
    endcase
  endfunction

  // Decode, register writes, read mux and scan next-state.
  always_comb begin
    hit_c       = (addr[31:5] == BASE_ADDR[31:5]) && (we || re);
    off_c       = addr[4:2];
    seg_reg_nx  = seg_reg;
    led_nx      = led;
    ctrl_nx     = ctrl_reg;
    rdata_nx    = 32'd0;
    scan_cnt_nx = scan_cnt;
    idx_nx      = idx;

    if (hit_c && we) begin
      case (off_c)
        OFF_SEG:  seg_reg_nx = wdata;
        OFF_LED:  led_nx     = wdata[15:0];
        OFF_CTRL: ctrl_nx    = wdata[8:0];
        default:  ;
      endcase
    end else if (hit_c && re) begin
      case (off_c)
        OFF_SEG:  rdata_nx = seg_reg;
        OFF_LED:  rdata_nx = {16'd0, led};
        OFF_CTRL: rdata_nx = {23'd0, ctrl_reg};
        OFF_SW:   rdata_nx = {16'd0, sw_filtered};
        default:  rdata_nx = 32'd0;
      endcase
    end

    if (scan_cnt == SCAN_DIV - 16'd1) begin
      scan_cnt_nx = 16'd0;
      idx_nx      = idx + IDX_W'(1);
    end else begin
      scan_cnt_nx = scan_cnt + 16'd1;
    end

    // Display outputs follow the post-edge state so an/seg match idx and the registers.
    nib_c  = 4'(seg_reg_nx >> {idx_nx, 2'b00});
    seg_nx = hex_glyph(nib_c);
    if (ctrl_nx[0] && !ctrl_nx[4'(idx_nx) + 4'd1])
      an_nx = ~(8'd1 << idx_nx);
    else
      an_nx = 8'hFF;
  end

  // Register file, response and display state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_reg  <= 32'd0;
      led      <= 16'd0;
      ctrl_reg <= 9'h001;
      scan_cnt <= 16'd0;
      idx      <= '0;
      ack      <= 1'b0;
      rdata    <= 32'd0;
      an       <= 8'hFE;
      seg      <= 8'hC0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      seg_reg  <= seg_reg_nx;
      led      <= led_nx;
      ctrl_reg <= ctrl_nx;
      scan_cnt <= scan_cnt_nx;
      idx      <= idx_nx;
      ack      <= hit_c;
      rdata    <= rdata_nx;
      an       <= an_nx;
      seg      <= seg_nx;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

`ifdef MMIO_SEG_DEBOUNCE_EN
  logic [19:0] db_cnt [SW_W];

  // Per-bit counter: accept a change only after it holds for DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_filtered <= '0;
      for (int i = 0; i < int'(SW_W); i++) db_cnt[i] <= 20'd0;
    end else begin
      for (int i = 0; i < int'(SW_W); i++) begin
        if (sw_sync[i] != sw_filtered[i]) begin
          if (db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
            sw_filtered[i] <= sw_sync[i];
            db_cnt[i]      <= 20'd0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 20'd1;
          end
        end else begin
          db_cnt[i] <= 20'd0;
        end
      end
    end
  end
`else
  always_comb sw_filtered = sw_sync;
`endif

endmodule
